// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive frame controller: state encoding,
// sample-point offset and the supported oversampling ratios.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam int SP_OFFSET = 2;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // The voted bit from data_sampling becomes readable this many edges past mid-bit.
  function automatic logic [4:0] sample_point(input logic [5:0] presc);
    return presc[5:1] + 5'(SP_OFFSET);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the frame controller, data_sampling and the line/consumer side.
interface uart_rx_ctrl_if #(parameter int DATA_WIDTH = 8);
  logic                  RX_IN;
  logic [5:0]            Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  sampled_bit;
  logic                  dat_samp_en;
  logic [4:0]            edge_cnt;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit,
    input  dat_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit,
    output dat_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_ctrl_edge_bit_counter.sv
// Oversample edge counter with bit counter; wraps at prescale-1 and clears
// whenever the frame is inactive or about to end.
module edge_bit_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [5:0] prescale_i,
  output logic [4:0] edge_cnt_o,
  output logic [3:0] bit_cnt_o,
  output logic       bit_end_o
);

  logic [4:0] edge_q, edge_d;
  logic [3:0] bit_q, bit_d;

  always_comb begin
    edge_d    = edge_q;
    bit_d     = bit_q;
    bit_end_o = ({1'b0, edge_q} == (prescale_i - 6'd1));
    if (clr_i || !en_i) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (bit_end_o) begin
      edge_d = '0;
      bit_d  = bit_q + 4'd1;
    end else begin
      edge_d = edge_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: drives data_sampling, deserializes the frame
// LSB-first and reports the byte or parity/stop errors as one-cycle pulses.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_rx_ctrl_if.slave  bus
);

  state_e                state_q, state_d;
  logic [5:0]            prescale_q;
  logic                  par_en_q, par_typ_q;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_bad_q, par_bad_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;
  logic                  samp_en_q;

  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       bit_end;
  logic       start_det;
  logic       sp_hit;

  assign start_det = (state_q == ST_IDLE) && !bus.RX_IN;
  assign sp_hit    = (edge_cnt == sample_point(prescale_q));

  // Clearing on the next state lets the counters be zero on the first IDLE cycle.
  edge_bit_counter u_cnt (
    .clk        (CLK),
    .rst_n      (RST),
    .en_i       (state_q != ST_IDLE),
    .clr_i      (state_d == ST_IDLE),
    .prescale_i (prescale_q),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt),
    .bit_end_o  (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    par_bad_d = par_bad_q;
    p_data_d  = p_data_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    serr_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        par_bad_d = 1'b0;
        if (!bus.RX_IN) state_d = ST_START;
      end
      ST_START: begin
        if (sp_hit && bus.sampled_bit) state_d = ST_IDLE;
        else if (bit_end)              state_d = ST_DATA;
      end
      ST_DATA: begin
        if (sp_hit) begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_cnt == 4'(i + 1)) shreg_d[i] = bus.sampled_bit;
          end
        end
        if (bit_end && (bit_cnt == 4'(DATA_WIDTH)))
          state_d = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (sp_hit) par_bad_d = bus.sampled_bit != ((^shreg_q) ^ par_typ_q);
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Leave at the sample point so a back-to-back start bit is not missed.
        if (sp_hit) begin
          state_d = ST_IDLE;
          serr_d  = !bus.sampled_bit;
          perr_d  = par_bad_q;
          if (bus.sampled_bit && !par_bad_q) begin
            valid_d  = 1'b1;
            p_data_d = shreg_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      shreg_q    <= '0;
      par_bad_q  <= 1'b0;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
      samp_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      par_bad_q <= par_bad_d;
      p_data_q  <= p_data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
      samp_en_q <= (state_d != ST_IDLE);
      if (start_det) begin
        prescale_q <= bus.Prescale;
        par_en_q   <= bus.PAR_EN;
        par_typ_q  <= bus.PAR_TYP;
      end
    end
  end

  assign bus.dat_samp_en = samp_en_q;
  assign bus.edge_cnt    = edge_cnt;
  assign bus.P_DATA      = p_data_q;
  assign bus.data_valid  = valid_q;
  assign bus.par_err     = perr_q;
  assign bus.stp_err     = serr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: serial line stimulus, a behavioural
// data_sampling neighbour, and a queue-based scoreboard checked by a monitor.
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  localparam int DW = 8;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  uart_rx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic          valid;
    logic          perr;
    logic          serr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   passed = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endfunction

  function automatic logic maj(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Neighbour model: three mid-bit samples, majority registered one edge later.
  logic [2:0] smp;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      smp             <= '0;
      bus.sampled_bit <= 1'b0;
    end else if (bus.dat_samp_en) begin
      if (int'(bus.edge_cnt) == int'(bus.Prescale) / 2 - 2) smp[0] <= bus.RX_IN;
      if (int'(bus.edge_cnt) == int'(bus.Prescale) / 2 - 1) smp[1] <= bus.RX_IN;
      if (int'(bus.edge_cnt) == int'(bus.Prescale) / 2)     smp[2] <= bus.RX_IN;
      if (int'(bus.edge_cnt) == int'(bus.Prescale) / 2 + 1) bus.sampled_bit <= maj(smp);
    end else begin
      smp <= '0;
    end
  end

  // Monitor: every output pulse is matched against the next expected frame outcome.
  initial begin
    logic [DW-1:0] last_good;
    logic          prev_pulse;
    logic          pulse;
    exp_t          e;
    last_good  = '0;
    prev_pulse = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        last_good  = '0;
        prev_pulse = 1'b0;
      end else begin
        pulse = bus.data_valid | bus.par_err | bus.stp_err;
        if (pulse) begin
          chk("pulse_back_to_back", 32'(prev_pulse), 32'd0);
          if (expq.size() == 0) begin
            chk("unexpected_pulse", 32'({bus.data_valid, bus.par_err, bus.stp_err}), 32'd0);
          end else begin
            e = expq.pop_front();
            chk("data_valid", 32'(bus.data_valid), 32'(e.valid));
            chk("par_err", 32'(bus.par_err), 32'(e.perr));
            chk("stp_err", 32'(bus.stp_err), 32'(e.serr));
            if (e.valid) last_good = e.data;
            chk("P_DATA", 32'(bus.P_DATA), 32'(last_good));
          end
        end
        prev_pulse = pulse;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  task automatic drive_bit(input logic b, input int presc);
    bus.RX_IN = b;
    repeat (presc) @(negedge CLK);
  endtask

  task automatic idle_bits(input int n, input int presc);
    bus.RX_IN = 1'b1;
    repeat (n * presc) @(negedge CLK);
  endtask

  // Reference outcome comes straight from the frame contents.
  task automatic send_frame(input logic [DW-1:0] d, input int presc, input logic pen,
                            input logic ptyp, input logic parbit, input logic stopbit);
    exp_t e;
    logic exp_par;
    exp_par = (^d) ^ ptyp;
    e.perr  = pen && (parbit != exp_par);
    e.serr  = !stopbit;
    e.valid = !e.perr && !e.serr;
    e.data  = d;
    expq.push_back(e);
    bus.Prescale = 6'(presc);
    bus.PAR_EN   = pen;
    bus.PAR_TYP  = ptyp;
    drive_bit(1'b0, presc);
    for (int i = 0; i < DW; i++) drive_bit(d[i], presc);
    if (pen) drive_bit(parbit, presc);
    drive_bit(stopbit, presc);
  endtask

  initial begin
    int          presc;
    logic        pen, ptyp, parbit, stopbit;
    logic [DW-1:0] d;
    logic [DW-1:0] ab;

    RST          = 1'b0;
    bus.RX_IN    = 1'b1;
    bus.Prescale = PRESCALE_8;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_data_valid", 32'(bus.data_valid), 32'd0);
    chk("rst_par_err", 32'(bus.par_err), 32'd0);
    chk("rst_stp_err", 32'(bus.stp_err), 32'd0);
    chk("rst_P_DATA", 32'(bus.P_DATA), 32'd0);
    chk("rst_edge_cnt", 32'(bus.edge_cnt), 32'd0);
    chk("rst_dat_samp_en", 32'(bus.dat_samp_en), 32'd0);
    RST = 1'b1;
    idle_bits(2, 8);
    chk("idle_edge_cnt", 32'(bus.edge_cnt), 32'd0);

    // Good frame with dat_samp_en held from detection to the stop sample point.
    fork
      send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1);
      begin
        @(negedge CLK);
        for (int j = 0; j <= 86; j++) begin
          chk("dat_samp_en_frame", 32'(bus.dat_samp_en), 32'd1);
          @(negedge CLK);
        end
        chk("dat_samp_en_after_stop", 32'(bus.dat_samp_en), 32'd0);
      end
    join
    idle_bits(1, 8);

    send_frame(8'hA5, 16, 1'b1, 1'b1, 1'b0, 1'b1);
    idle_bits(1, 16);

    send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_bits(2, 32);

    // Short low glitch must be filtered.
    bus.Prescale = PRESCALE_8;
    bus.RX_IN    = 1'b0;
    repeat (3) @(negedge CLK);
    bus.RX_IN = 1'b1;
    repeat (20) @(negedge CLK);
    chk("false_start_edge_cnt", 32'(bus.edge_cnt), 32'd0);
    chk("false_start_samp_en", 32'(bus.dat_samp_en), 32'd0);

    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_bits(2, 8);

    // Abort a frame with reset during data bit 4.
    ab           = 8'h9B;
    bus.Prescale = PRESCALE_8;
    bus.PAR_EN   = 1'b0;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(ab[i], 8);
    bus.RX_IN = ab[4];
    repeat (3) @(negedge CLK);
    chk("pre_reset_samp_en", 32'(bus.dat_samp_en), 32'd1);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_data_valid", 32'(bus.data_valid), 32'd0);
    chk("mid_rst_par_err", 32'(bus.par_err), 32'd0);
    chk("mid_rst_stp_err", 32'(bus.stp_err), 32'd0);
    chk("mid_rst_P_DATA", 32'(bus.P_DATA), 32'd0);
    chk("mid_rst_edge_cnt", 32'(bus.edge_cnt), 32'd0);
    chk("mid_rst_samp_en", 32'(bus.dat_samp_en), 32'd0);
    bus.RX_IN = 1'b1;
    repeat (2) @(negedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    idle_bits(2, 8);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_bits(1, 8);

    // Randomized frames across ratios, parity modes and injected errors.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       presc = 8;
        1:       presc = 16;
        default: presc = 32;
      endcase
      pen     = 1'($urandom_range(0, 1));
      ptyp    = 1'($urandom_range(0, 1));
      d       = DW'($urandom);
      parbit  = (^d) ^ ptyp;
      if ($urandom_range(0, 4) == 0) parbit = ~parbit;
      stopbit = ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1;
      send_frame(d, presc, pen, ptyp, parbit, stopbit);
      idle_bits(stopbit ? $urandom_range(0, 2) : 2, presc);
    end

    idle_bits(2, 32);
    for (int i = 0; i < 2000 && expq.size() != 0; i++) @(negedge CLK);
    chk("drain_queue", 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
